// File: rtl/zb_text_pkg.sv
// Shared constants, FSM encoding and cell-address helpers for the character-cell text buffer.
package zb_text_pkg;

    localparam int COLS  = 40;
    localparam int ROWS  = 25;
    localparam int CELLS = COLS * ROWS;

    localparam logic [15:0] BLANK   = 16'h0020;
    localparam logic [15:0] CODE_LF = 16'h000A;
    localparam logic [15:0] CODE_BS = 16'h0008;
    localparam logic [15:0] CODE_FF = 16'h000C;

    localparam logic [5:0] LAST_COL  = 6'(COLS - 1);
    localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);
    localparam logic [9:0] LAST_CELL = 10'(CELLS - 1);
    localparam logic [9:0] YPOS_END  = 10'(ROWS * 16);

    typedef enum logic [1:0] {
        CLR_ALL,
        IDLE,
        CLR_ROW
    } state_e;

    // Logical row to physical row under the hardware scroll offset.
    function automatic logic [4:0] phys_row(input logic [4:0] lrow, input logic [4:0] top);
        logic [5:0] sum;
        sum = {1'b0, lrow} + {1'b0, top};
        if (sum >= 6'(ROWS)) sum = sum - 6'(ROWS);
        return sum[4:0];
    endfunction

    // phys*40 + col, built from shifts so no multiplier is needed.
    function automatic logic [9:0] cell_addr(input logic [4:0] phys, input logic [5:0] col);
        return {phys, 5'b0} + {2'b0, phys, 3'b0} + {4'b0, col};
    endfunction

endpackage

// File: rtl/zb_text_ram.sv
// 1000x16 simple dual-port cell store: one write port, one synchronous read-first read port.
module zb_text_ram
    import zb_text_pkg::*;
(
    input  logic        clk,
    input  logic        we_i,
    input  logic [9:0]  waddr_i,
    input  logic [15:0] wdata_i,
    input  logic [9:0]  raddr_i,
    output logic [15:0] rdata_o
);

    logic [15:0] mem_q [CELLS];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/zb_text_buffer.sv
// 40x25 character-cell buffer: CPU-side code stream with cursor/scroll, pixel-rate display lookup.
//   state   | meaning
//   CLR_ALL | blanking all 1000 cells, then home cursor and scroll offset
//   IDLE    | accepting codes from the CPU side
//   CLR_ROW | blanking the physical row that just became the bottom row
module zb_text_buffer
    import zb_text_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    input  logic [15:0] wr_code,
    output logic        wr_ready,
    input  logic [9:0]  xpos,
    input  logic [9:0]  ypos,
    output logic [15:0] ZBcode,
    output logic [5:0]  cur_col,
    output logic [4:0]  cur_row
);

    state_e      state_q, state_d;
    logic [9:0]  idx_q, idx_d;
    logic [5:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [4:0]  top_q, top_d;
    logic [4:0]  clr_phys_q, clr_phys_d;
    logic        rd_vld_q;

    logic        accept, is_lf, is_bs, is_ff, is_prn;
    logic        row_adv, scroll, idx_done;
    logic        we;
    logic [9:0]  waddr, raddr;
    logic [15:0] wdata, rdata;
    logic [6:0]  disp_col7;
    logic [5:0]  disp_col;

    assign accept   = wr_valid && (state_q == IDLE);
    assign is_lf    = accept && (wr_code == CODE_LF);
    assign is_bs    = accept && (wr_code == CODE_BS);
    assign is_ff    = accept && (wr_code == CODE_FF);
    assign is_prn   = accept && !(wr_code == CODE_LF || wr_code == CODE_BS || wr_code == CODE_FF);
    assign row_adv  = is_lf || (is_prn && (col_q == LAST_COL));
    assign scroll   = row_adv && (row_q == LAST_ROW);
    assign idx_done = (state_q == CLR_ALL) ? (idx_q == LAST_CELL) : (idx_q == {4'b0, LAST_COL});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= CLR_ALL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CLR_ALL: if (idx_done) state_d = IDLE;
            IDLE: begin
                if (is_ff)       state_d = CLR_ALL;
                else if (scroll) state_d = CLR_ROW;
            end
            CLR_ROW: if (idx_done) state_d = IDLE;
            default: state_d = CLR_ALL;
        endcase
    end

    always_comb begin
        wr_ready = 1'b0;
        we       = 1'b0;
        waddr    = '0;
        wdata    = BLANK;
        unique case (state_q)
            CLR_ALL: begin
                we    = 1'b1;
                waddr = idx_q;
            end
            CLR_ROW: begin
                we    = 1'b1;
                waddr = cell_addr(clr_phys_q, idx_q[5:0]);
            end
            IDLE: begin
                wr_ready = 1'b1;
                if (is_prn) begin
                    we    = 1'b1;
                    waddr = cell_addr(phys_row(row_q, top_q), col_q);
                    wdata = wr_code;
                end else if (is_bs && col_q != '0) begin
                    we    = 1'b1;
                    waddr = cell_addr(phys_row(row_q, top_q), col_q - 6'd1);
                end else if (is_bs && row_q != '0) begin
                    we    = 1'b1;
                    waddr = cell_addr(phys_row(row_q - 5'd1, top_q), LAST_COL);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        idx_d      = idx_q;
        col_d      = col_q;
        row_d      = row_q;
        top_d      = top_q;
        clr_phys_d = clr_phys_q;
        unique case (state_q)
            CLR_ALL: begin
                idx_d = idx_q + 10'd1;
                if (idx_done) begin
                    idx_d = '0;
                    col_d = '0;
                    row_d = '0;
                    top_d = '0;
                end
            end
            CLR_ROW: idx_d = idx_done ? '0 : idx_q + 10'd1;
            IDLE: begin
                idx_d = '0;
                if (is_bs) begin
                    if (col_q != '0) begin
                        col_d = col_q - 6'd1;
                    end else if (row_q != '0) begin
                        col_d = LAST_COL;
                        row_d = row_q - 5'd1;
                    end
                end else if (row_adv) begin
                    col_d = '0;
                    // At the bottom the old top row is recycled as the new bottom row.
                    if (scroll) begin
                        top_d      = (top_q == LAST_ROW) ? '0 : top_q + 5'd1;
                        clr_phys_d = top_q;
                    end else begin
                        row_d = row_q + 5'd1;
                    end
                end else if (is_prn) begin
                    col_d = col_q + 6'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            top_q      <= '0;
            clr_phys_q <= '0;
            rd_vld_q   <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            col_q      <= col_d;
            row_q      <= row_d;
            top_q      <= top_d;
            clr_phys_q <= clr_phys_d;
            rd_vld_q   <= 1'b1;
        end
    end

    // Look one pixel ahead to cover the registered read; out-of-grid positions read cell 0.
    assign disp_col7 = 7'(({1'b0, xpos} + 11'd1) >> 4);
    assign disp_col  = (disp_col7 < 7'(COLS)) ? disp_col7[5:0] : 6'd0;
    assign raddr     = (ypos >= YPOS_END) ? 10'd0
                                          : cell_addr(phys_row(ypos[8:4], top_q), disp_col);

    zb_text_ram u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    // The RAM read register has no reset, so hold the output at zero until the first live edge.
    assign ZBcode  = rd_vld_q ? rdata : 16'h0000;
    assign cur_col = col_q;
    assign cur_row = row_q;

endmodule

// File: tb/tb_zb_text_buffer.sv
// Self-checking bench for zb_text_buffer against a logical-screen reference model.
module tb_zb_text_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_code = 16'h0000;
    logic        wr_ready;
    logic [9:0]  xpos = 10'd0;
    logic [9:0]  ypos = 10'd0;
    logic [15:0] ZBcode;
    logic [5:0]  cur_col;
    logic [4:0]  cur_row;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: screen kept in logical row order; scrolling shifts rows up.
    logic [15:0] scr [25][40];
    int          mc, mr, nscroll;

    always #5 clk = ~clk;

    zb_text_buffer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_code  (wr_code),
        .wr_ready (wr_ready),
        .xpos     (xpos),
        .ypos     (ypos),
        .ZBcode   (ZBcode),
        .cur_col  (cur_col),
        .cur_row  (cur_row)
    );

    task automatic model_clear();
        for (int r = 0; r < 25; r++)
            for (int c = 0; c < 40; c++) scr[r][c] = 16'h0020;
        mc = 0;
        mr = 0;
        nscroll = 0;
    endtask

    task automatic model_newrow(inout int busy);
        if (mr < 24) begin
            mr++;
        end else begin
            for (int r = 0; r < 24; r++)
                for (int c = 0; c < 40; c++) scr[r][c] = scr[r+1][c];
            for (int c = 0; c < 40; c++) scr[24][c] = 16'h0020;
            nscroll++;
            busy = 40;
        end
    endtask

    task automatic model_put(input logic [15:0] code, output int busy);
        busy = 0;
        if (code == 16'h000C) begin
            model_clear();
            busy = 1000;
        end else if (code == 16'h000A) begin
            mc = 0;
            model_newrow(busy);
        end else if (code == 16'h0008) begin
            if (mc > 0) begin
                mc--;
                scr[mr][mc] = 16'h0020;
            end else if (mr > 0) begin
                mr--;
                mc = 39;
                scr[mr][mc] = 16'h0020;
            end
        end else begin
            scr[mr][mc] = code;
            mc++;
            if (mc == 40) begin
                mc = 0;
                model_newrow(busy);
            end
        end
    endtask

    function automatic logic [15:0] exp_disp(input int x, input int y);
        int lr, c;
        if (y >= 400) begin
            lr = (25 - (nscroll % 25)) % 25;
            c  = 0;
        end else begin
            lr = y / 16;
            c  = (x + 1) / 16;
            if (c == 40) c = 0;
        end
        return scr[lr][c];
    endfunction

    function automatic logic [15:0] rand_prn();
        return 16'($urandom_range(33, 65535));
    endfunction

    // Offers a code, waits for acceptance, then counts cycles with wr_ready low (-1 on timeout).
    task automatic send(input logic [15:0] code, output int busy);
        int n;
        busy = -1;
        wr_code  = code;
        wr_valid = 1'b1;
        n = 0;
        while (wr_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (wr_ready === 1'b1) begin
            @(posedge clk);
            #1 wr_valid = 1'b0;
            n = 0;
            @(negedge clk);
            while (wr_ready !== 1'b1 && n < 3000) begin
                n++;
                @(negedge clk);
            end
            busy = (n >= 3000) ? -1 : n;
        end else begin
            wr_valid = 1'b0;
        end
    endtask

    task automatic read_disp(input int x, input int y, output logic [15:0] d);
        xpos = 10'(x);
        ypos = 10'(y);
        @(posedge clk);
        @(negedge clk);
        d = ZBcode;
    endtask

    task automatic test_reset();
        int n;
        logic [15:0] d;
        rst_n    = 1'b0;
        wr_valid = 1'b1;
        wr_code  = 16'h0041;
        repeat (3) @(negedge clk);
        n_cmp += 4;
        if (ZBcode !== 16'h0000) begin n_fail++; $display("FAIL reset_zbcode: got %h expected 0000", ZBcode); end
        if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", wr_ready); end
        if (cur_col !== 6'd0) begin n_fail++; $display("FAIL reset_col: got %0d expected 0", cur_col); end
        if (cur_row !== 5'd0) begin n_fail++; $display("FAIL reset_row: got %0d expected 0", cur_row); end
        rst_n = 1'b1;
        n = 0;
        while (n < 3000) begin
            @(posedge clk);
            n++;
            #1;
            if (wr_ready === 1'b1) break;
        end
        wr_valid = 1'b0;
        n_cmp++;
        if (n !== 1000) begin n_fail++; $display("FAIL reset_ready_delay: got %0d cycles expected 1000", n); end
        model_clear();
        @(negedge clk);
        n_cmp++;
        if (cur_col !== 6'd0) begin n_fail++; $display("FAIL reset_not_consumed: col %0d expected 0", cur_col); end
        for (int r = 0; r < 25; r++)
            for (int c = 0; c < 40; c++) begin
                read_disp(c * 16 + int'($urandom_range(0, 14)), r * 16 + int'($urandom_range(0, 15)), d);
                n_cmp++;
                if (d !== 16'h0020) begin n_fail++; $display("FAIL reset_blank r%0d c%0d: got %h expected 0020", r, c, d); end
            end
    endtask

    task automatic test_print();
        int b, eb;
        logic [15:0] d, e;
        int xs[8] = '{0, 14, 15, 16, 30, 31, 639, 622};
        send(16'h0041, b); model_put(16'h0041, eb);
        n_cmp++;
        if (b !== eb) begin n_fail++; $display("FAIL print_busy: got %0d expected %0d", b, eb); end
        send(16'h0042, b); model_put(16'h0042, eb);
        n_cmp += 3;
        if (b !== eb) begin n_fail++; $display("FAIL print_busy2: got %0d expected %0d", b, eb); end
        if (cur_col !== 6'(mc)) begin n_fail++; $display("FAIL print_col: got %0d expected %0d", cur_col, mc); end
        if (cur_row !== 5'(mr)) begin n_fail++; $display("FAIL print_row: got %0d expected %0d", cur_row, mr); end
        foreach (xs[i]) begin
            read_disp(xs[i], 7, d);
            e = exp_disp(xs[i], 7);
            n_cmp++;
            if (d !== e) begin n_fail++; $display("FAIL print_lookup x%0d: got %h expected %h", xs[i], d, e); end
        end
    endtask

    task automatic test_wrap();
        int b, eb;
        logic [15:0] d, e, code;
        for (int i = 0; i < 38; i++) begin
            code = rand_prn();
            send(code, b); model_put(code, eb);
            n_cmp++;
            if (b !== eb) begin n_fail++; $display("FAIL wrap_busy %0d: got %0d expected %0d", i, b, eb); end
        end
        n_cmp += 2;
        if (cur_col !== 6'(mc) || mc != 0) begin n_fail++; $display("FAIL wrap_col: got %0d expected %0d", cur_col, mc); end
        if (cur_row !== 5'(mr) || mr != 1) begin n_fail++; $display("FAIL wrap_row: got %0d expected %0d", cur_row, mr); end
        read_disp(0, 16, d);
        e = exp_disp(0, 16);
        n_cmp++;
        if (d !== e) begin n_fail++; $display("FAIL wrap_next_row: got %h expected %h", d, e); end
        read_disp(627, 3, d);
        e = exp_disp(627, 3);
        n_cmp++;
        if (d !== e) begin n_fail++; $display("FAIL wrap_last_col: got %h expected %h", d, e); end
    endtask

    task automatic test_backspace();
        int b, eb;
        logic [15:0] d, e;
        send(16'h0008, b); model_put(16'h0008, eb);
        n_cmp += 3;
        if (b !== eb) begin n_fail++; $display("FAIL bs_busy: got %0d expected %0d", b, eb); end
        if (cur_col !== 6'd39) begin n_fail++; $display("FAIL bs_wrap_col: got %0d expected 39", cur_col); end
        if (cur_row !== 5'd0) begin n_fail++; $display("FAIL bs_wrap_row: got %0d expected 0", cur_row); end
        read_disp(626, 0, d);
        e = exp_disp(626, 0);
        n_cmp++;
        if (d !== e || e !== 16'h0020) begin n_fail++; $display("FAIL bs_cell_blank: got %h expected %h", d, e); end
        send(16'h000C, b); model_put(16'h000C, eb);
        n_cmp++;
        if (b !== eb) begin n_fail++; $display("FAIL clear_busy: got %0d expected %0d", b, eb); end
        read_disp(20, 2, d);
        n_cmp++;
        if (d !== exp_disp(20, 2)) begin n_fail++; $display("FAIL clear_cell: got %h expected %h", d, exp_disp(20, 2)); end
        send(16'h0055, b); model_put(16'h0055, eb);
        send(16'h0008, b); model_put(16'h0008, eb);
        send(16'h0008, b); model_put(16'h0008, eb);
        n_cmp += 3;
        if (b !== eb) begin n_fail++; $display("FAIL bs_home_busy: got %0d expected %0d", b, eb); end
        if (cur_col !== 6'd0) begin n_fail++; $display("FAIL bs_home_col: got %0d expected 0", cur_col); end
        if (cur_row !== 5'd0) begin n_fail++; $display("FAIL bs_home_row: got %0d expected 0", cur_row); end
        read_disp(1, 1, d);
        n_cmp++;
        if (d !== exp_disp(1, 1)) begin n_fail++; $display("FAIL bs_home_cell: got %h expected %h", d, exp_disp(1, 1)); end
    endtask

    task automatic test_scroll();
        int b, eb, k;
        logic [15:0] d, e, code;
        for (int r = 0; r < 24; r++) begin
            k = int'($urandom_range(1, 39));
            for (int i = 0; i < k; i++) begin
                code = rand_prn();
                send(code, b); model_put(code, eb);
            end
            send(16'h000A, b); model_put(16'h000A, eb);
        end
        for (int i = 0; i < 5; i++) begin
            code = rand_prn();
            send(code, b); model_put(code, eb);
        end
        send(16'h000A, b); model_put(16'h000A, eb);
        n_cmp += 3;
        if (b !== eb || eb != 40) begin n_fail++; $display("FAIL scroll_busy: got %0d expected %0d", b, eb); end
        if (cur_row !== 5'd24) begin n_fail++; $display("FAIL scroll_row: got %0d expected 24", cur_row); end
        if (cur_col !== 6'd0) begin n_fail++; $display("FAIL scroll_col: got %0d expected 0", cur_col); end
        for (int r = 0; r < 25; r++)
            for (int c = 0; c < 40; c++) begin
                int x, y;
                x = c * 16 + int'($urandom_range(0, 15));
                y = r * 16 + int'($urandom_range(0, 15));
                read_disp(x, y, d);
                e = exp_disp(x, y);
                n_cmp++;
                if (d !== e) begin n_fail++; $display("FAIL scroll_screen x%0d y%0d: got %h expected %h", x, y, d, e); end
            end
        read_disp(100, 450, d);
        e = exp_disp(100, 450);
        n_cmp++;
        if (d !== e) begin n_fail++; $display("FAIL scroll_offscreen: got %h expected %h", d, e); end
    endtask

    task automatic test_back_to_back();
        int b, eb, p;
        logic [15:0] d, e, code;
        for (int i = 0; i < 400; i++) begin
            p = int'($urandom_range(0, 99));
            if (p < 80)      code = rand_prn();
            else if (p < 90) code = 16'h000A;
            else             code = 16'h0008;
            send(code, b); model_put(code, eb);
            n_cmp++;
            if (b !== eb) begin n_fail++; $display("FAIL b2b_busy op%0d code %h: got %0d expected %0d", i, code, b, eb); end
        end
        n_cmp += 2;
        if (cur_col !== 6'(mc)) begin n_fail++; $display("FAIL b2b_col: got %0d expected %0d", cur_col, mc); end
        if (cur_row !== 5'(mr)) begin n_fail++; $display("FAIL b2b_row: got %0d expected %0d", cur_row, mr); end
        for (int r = 0; r < 25; r++)
            for (int c = 0; c < 40; c++) begin
                int x, y;
                x = c * 16 + int'($urandom_range(0, 15));
                y = r * 16 + int'($urandom_range(0, 15));
                read_disp(x, y, d);
                e = exp_disp(x, y);
                n_cmp++;
                if (d !== e) begin n_fail++; $display("FAIL b2b_screen x%0d y%0d: got %h expected %h", x, y, d, e); end
            end
    endtask

    task automatic test_reset_mid_scroll();
        int b, eb, n;
        logic [15:0] d;
        for (int i = 0; i < 25; i++) begin
            send(16'h000A, b); model_put(16'h000A, eb);
        end
        xpos = 10'd5;
        ypos = 10'd5;
        wr_code  = 16'h000A;
        wr_valid = 1'b1;
        @(posedge clk);
        #1 wr_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp += 4;
        if (ZBcode !== 16'h0000) begin n_fail++; $display("FAIL midrst_zbcode: got %h expected 0000", ZBcode); end
        if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b expected 0", wr_ready); end
        if (cur_col !== 6'd0) begin n_fail++; $display("FAIL midrst_col: got %0d expected 0", cur_col); end
        if (cur_row !== 5'd0) begin n_fail++; $display("FAIL midrst_row: got %0d expected 0", cur_row); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (n < 3000) begin
            @(posedge clk);
            n++;
            #1;
            if (wr_ready === 1'b1) break;
        end
        n_cmp++;
        if (n !== 1000) begin n_fail++; $display("FAIL midrst_ready_delay: got %0d cycles expected 1000", n); end
        model_clear();
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            int x, y;
            x = int'($urandom_range(0, 639));
            y = int'($urandom_range(0, 399));
            read_disp(x, y, d);
            n_cmp++;
            if (d !== exp_disp(x, y)) begin n_fail++; $display("FAIL midrst_blank x%0d y%0d: got %h expected %h", x, y, d, exp_disp(x, y)); end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_print();
        test_wrap();
        test_backspace();
        test_scroll();
        test_back_to_back();
        test_reset_mid_scroll();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
